// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, sub-word extract/merge, fault detection.
// Optional LSU_BYTE_WRITE_EN adds o_MemByteEnable and replaces read-modify-write with a single masked write.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              i_Clock,
  input  logic              i_Reset_n,
  input  logic              i_Valid,
  output logic              o_Ready,
  input  logic              i_Load,
  input  logic              i_Store,
  input  logic [2:0]        i_Mode,
  input  logic [ADDR_W-1:0] i_Address,
  input  logic [31:0]       i_StoreData,
  output logic              o_Done,
  output logic              o_Fault,
  output logic [31:0]       o_LoadData,
  output logic              o_MemReadEnable,
  output logic              o_MemWriteEnable,
  output logic [ADDR_W-1:0] o_MemAddress,
  output logic [31:0]       o_MemDataOut,
  output logic [2:0]        o_MemMode,
`ifdef LSU_BYTE_WRITE_EN
  output logic [3:0]        o_MemByteEnable,
`endif
  input  logic [31:0]       i_MemDataIn
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    RMW_RD,
    RMW_WR
  } lsuState_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  lsuState_t   stateReg;
  logic [2:0]  modeReg;
  logic [1:0]  laneReg;
  logic [3:0]  maskReg;
  logic [31:0] wdataReg;

  logic [1:0]  reqSize;
  logic        modeBad;
  logic        misaligned;
  logic        reqFault;
  logic [3:0]  reqMask;
  logic [31:0] reqWdata;
  logic [31:0] mergedWord;

  assign o_Ready   = (stateReg == IDLE);
  assign o_MemMode = 3'b010;

  // Request decode; lane mask and lane-replicated data serve both the merge and byte-enable paths.
  always_comb begin
    reqSize = i_Mode[1:0];
    if (i_Load)
      modeBad = (i_Mode == 3'b011) || (i_Mode == 3'b110) || (i_Mode == 3'b111);
    else
      modeBad = (i_Mode >= 3'b011);
    misaligned = ((reqSize == SIZE_HALF) && i_Address[0]) ||
                 ((reqSize == SIZE_WORD) && (i_Address[1:0] != 2'b00));
    reqFault   = (i_Load == i_Store) || modeBad || misaligned;
    case (reqSize)
      SIZE_BYTE: begin
        reqMask  = 4'b0001 << i_Address[1:0];
        reqWdata = {4{i_StoreData[7:0]}};
      end
      SIZE_HALF: begin
        reqMask  = 4'b0011 << i_Address[1:0];
        reqWdata = {2{i_StoreData[15:0]}};
      end
      default: begin
        reqMask  = 4'b1111;
        reqWdata = i_StoreData;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gMergeLane
      assign mergedWord[gi*8 +: 8] = maskReg[gi] ? wdataReg[gi*8 +: 8] : i_MemDataIn[gi*8 +: 8];
    end
  endgenerate

  function automatic logic [31:0] loadExtract(input logic [2:0] mode, input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [31:0] shifted;
    logic [7:0]  byteVal;
    logic [15:0] halfVal;
    logic        signFill;
    shifted = word >> {lane, 3'b000};
    byteVal = shifted[7:0];
    halfVal = lane[1] ? word[31:16] : word[15:0];
    case (mode[1:0])
      SIZE_BYTE: begin
        signFill    = ~mode[2] & byteVal[7];
        loadExtract = {{24{signFill}}, byteVal};
      end
      SIZE_HALF: begin
        signFill    = ~mode[2] & halfVal[15];
        loadExtract = {{16{signFill}}, halfVal};
      end
      default: begin
        signFill    = 1'b0;
        loadExtract = word;
      end
    endcase
  endfunction

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      stateReg         <= IDLE;
      modeReg          <= 3'b000;
      laneReg          <= 2'b00;
      maskReg          <= 4'b0000;
      wdataReg         <= 32'h0;
      o_Done           <= 1'b0;
      o_Fault          <= 1'b0;
      o_LoadData       <= 32'h0;
      o_MemReadEnable  <= 1'b0;
      o_MemWriteEnable <= 1'b0;
      o_MemAddress     <= '0;
      o_MemDataOut     <= 32'h0;
`ifdef LSU_BYTE_WRITE_EN
      o_MemByteEnable  <= 4'b0000;
`endif
    end else begin
      o_Done  <= 1'b0;
      o_Fault <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (i_Valid) begin
            if (reqFault) begin
              o_Done  <= 1'b1;
              o_Fault <= 1'b1;
            end else begin
              modeReg      <= i_Mode;
              laneReg      <= i_Address[1:0];
              maskReg      <= reqMask;
              wdataReg     <= reqWdata;
              o_MemAddress <= {i_Address[ADDR_W-1:2], 2'b00};
              if (i_Load) begin
                stateReg        <= LOAD;
                o_MemReadEnable <= 1'b1;
`ifdef LSU_BYTE_WRITE_EN
              end else begin
                stateReg         <= WRITE;
                o_MemWriteEnable <= 1'b1;
                o_MemDataOut     <= reqWdata;
                o_MemByteEnable  <= reqMask;
              end
`else
              end else if (reqSize == SIZE_WORD) begin
                stateReg         <= WRITE;
                o_MemWriteEnable <= 1'b1;
                o_MemDataOut     <= reqWdata;
              end else begin
                stateReg        <= RMW_RD;
                o_MemReadEnable <= 1'b1;
              end
`endif
            end
          end
        end
        LOAD: begin
          o_MemReadEnable <= 1'b0;
          o_LoadData      <= loadExtract(modeReg, laneReg, i_MemDataIn);
          o_Done          <= 1'b1;
          stateReg        <= IDLE;
        end
        WRITE: begin
          o_MemWriteEnable <= 1'b0;
`ifdef LSU_BYTE_WRITE_EN
          o_MemByteEnable  <= 4'b0000;
`endif
          o_Done           <= 1'b1;
          stateReg         <= IDLE;
        end
        RMW_RD: begin
          // Memory read is combinational, so the merged word is ready in this same cycle.
          o_MemReadEnable  <= 1'b0;
          o_MemWriteEnable <= 1'b1;
          o_MemDataOut     <= mergedWord;
          stateReg         <= RMW_WR;
        end
        RMW_WR: begin
          o_MemWriteEnable <= 1'b0;
          o_Done           <= 1'b1;
          stateReg         <= IDLE;
        end
        default: begin
          o_MemReadEnable  <= 1'b0;
          o_MemWriteEnable <= 1'b0;
          stateReg         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver queues expectations, monitor checks each o_Done.
module tb_load_store_unit;

`ifdef LSU_BYTE_WRITE_EN
  localparam int SUB_LAT = 2;
  localparam int SUB_EN  = 1;
`else
  localparam int SUB_LAT = 3;
  localparam int SUB_EN  = 2;
`endif

  logic        clk = 1'b0;
  logic        rstN;
  logic        valid, ready, load, store;
  logic [2:0]  mode;
  logic [31:0] addr, sdata;
  logic        done, fault;
  logic [31:0] loadData;
  logic        rdEn, wrEn;
  logic [31:0] memAddr, memOut, memIn;
  logic [2:0]  memMode;
`ifdef LSU_BYTE_WRITE_EN
  logic [3:0]  byteEn;
`endif

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .i_Clock(clk), .i_Reset_n(rstN), .i_Valid(valid), .o_Ready(ready),
    .i_Load(load), .i_Store(store), .i_Mode(mode), .i_Address(addr), .i_StoreData(sdata),
    .o_Done(done), .o_Fault(fault), .o_LoadData(loadData),
    .o_MemReadEnable(rdEn), .o_MemWriteEnable(wrEn), .o_MemAddress(memAddr),
    .o_MemDataOut(memOut), .o_MemMode(memMode),
`ifdef LSU_BYTE_WRITE_EN
    .o_MemByteEnable(byteEn),
`endif
    .i_MemDataIn(memIn)
  );

  // Memory model: combinational read, posedge write, bench preload port.
  logic [31:0] mem [0:255];
  logic        plEn;
  logic [31:0] plAddr, plData;
  assign memIn = mem[memAddr[9:2]];
  always @(posedge clk) begin
    if (plEn) mem[plAddr[9:2]] <= plData;
    else if (wrEn) begin
`ifdef LSU_BYTE_WRITE_EN
      for (int b = 0; b < 4; b++)
        if (byteEn[b]) mem[memAddr[9:2]][b*8 +: 8] <= memOut[b*8 +: 8];
`else
      mem[memAddr[9:2]] <= memOut;
`endif
    end
  end

  typedef struct {
    int          id;
    logic        isLoad;
    logic        isStore;
    logic        fault;
    logic [31:0] data;
    int          lat;
    int          en;
    logic [31:0] maddr;
    logic [31:0] mval;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  exp_t monEntry;
  int   cyc = 0, checks = 0, errors = 0, wrCount = 0, enCount = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rstN) enCount = 0;
    else begin
      if (rdEn || wrEn) enCount++;
      if (wrEn) wrCount++;
      check("rd_wr_exclusive", {31'b0, rdEn & wrEn}, 32'h0);
      if (fault && !done) check("fault_without_done", {31'b0, fault}, 32'h0);
      if (done) begin
        if (sbq.size() == 0) begin
          check("unexpected_done", {31'b0, done}, 32'h0);
        end else begin
          monEntry = sbq.pop_front();
          check("fault", {31'b0, fault}, {31'b0, monEntry.fault});
          check("latency", cyc - monEntry.acc, monEntry.lat);
          check("mem_enables", enCount, monEntry.en);
          check("mem_mode", {29'b0, memMode}, 32'h2);
          if (monEntry.isLoad && !monEntry.fault) check("load_data", loadData, monEntry.data);
          if (monEntry.isStore && !monEntry.fault)
            check("mem_word", mem[monEntry.maddr[9:2]], monEntry.mval);
          $display("txn %0d done fault=%0b load_data=%h lat=%0d en=%0d", monEntry.id, fault,
                   loadData, cyc - monEntry.acc, enCount);
        end
        enCount = 0;
      end
    end
  end

  task automatic issue(input int id, input logic ld, input logic st, input logic [2:0] md,
                       input logic [31:0] a, input logic [31:0] d, input logic expF,
                       input logic [31:0] expD, input int lat, input int en, input logic [31:0] mval);
    exp_t e;
    int n = 0;
    valid = 1'b1; load = ld; store = st; mode = md; addr = a; sdata = d;
    while (!ready && n < 50) begin @(negedge clk); n++; end
    check("accept", {31'b0, ready}, 32'h1);
    if (!ready) begin valid = 1'b0; return; end
    e.id = id; e.isLoad = ld; e.isStore = st; e.fault = expF; e.data = expD;
    e.lat = lat; e.en = en; e.maddr = a; e.mval = mval; e.acc = cyc;
    @(posedge clk); #1;
    sbq.push_back(e);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check("drain", sbq.size(), 32'h0);
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    plEn = 1'b1; plAddr = a; plData = d;
    @(negedge clk);
    plEn = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    rstN = 1'b0; valid = 1'b0; load = 1'b0; store = 1'b0; mode = 3'b0;
    addr = 32'h0; sdata = 32'h0; plEn = 1'b0; plAddr = 32'h0; plData = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, ready}, 32'h1);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_fault", {31'b0, fault}, 32'h0);
    check("rst_rd_en", {31'b0, rdEn}, 32'h0);
    check("rst_wr_en", {31'b0, wrEn}, 32'h0);
    check("rst_mem_addr", memAddr, 32'h0);
    check("rst_mem_data", memOut, 32'h0);
    check("rst_load_data", loadData, 32'h0);
    rstN = 1'b1;
    @(negedge clk);

    // word store then load
    issue(1, 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0, 2, 1, 32'hDEADBEEF);
    issue(2, 1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 2, 1, 32'h0);
    drain();
    preload(32'h100, 32'h11223344);
    issue(3, 0, 1, 3'b000, 32'h102, 32'hFFFFFFAA, 0, 32'h0, SUB_LAT, SUB_EN, 32'h11AA3344);
    drain();

    // sub-word loads with sign/zero extension
    preload(32'h200, 32'h80FF7F01);
    issue(4,  1, 0, 3'b000, 32'h202, 32'h0, 0, 32'hFFFFFFFF, 2, 1, 32'h0);
    issue(5,  1, 0, 3'b100, 32'h202, 32'h0, 0, 32'h000000FF, 2, 1, 32'h0);
    issue(6,  1, 0, 3'b001, 32'h202, 32'h0, 0, 32'hFFFF80FF, 2, 1, 32'h0);
    issue(7,  1, 0, 3'b101, 32'h200, 32'h0, 0, 32'h00007F01, 2, 1, 32'h0);
    issue(8,  1, 0, 3'b000, 32'h201, 32'h0, 0, 32'h0000007F, 2, 1, 32'h0);
    issue(9,  1, 0, 3'b100, 32'h203, 32'h0, 0, 32'h00000080, 2, 1, 32'h0);
    issue(10, 1, 0, 3'b001, 32'h200, 32'h0, 0, 32'h00007F01, 2, 1, 32'h0);
    issue(11, 1, 0, 3'b010, 32'h200, 32'h0, 0, 32'h80FF7F01, 2, 1, 32'h0);

    // faults: one cycle, no memory access, load result untouched
    issue(12, 1, 0, 3'b010, 32'h101, 32'h0, 1, 32'h0, 1, 0, 32'h0);
    issue(13, 0, 1, 3'b001, 32'h103, 32'h5555, 1, 32'h0, 1, 0, 32'h0);
    issue(14, 1, 0, 3'b011, 32'h100, 32'h0, 1, 32'h0, 1, 0, 32'h0);
    issue(15, 1, 1, 3'b010, 32'h100, 32'h0, 1, 32'h0, 1, 0, 32'h0);
    issue(16, 0, 0, 3'b010, 32'h100, 32'h0, 1, 32'h0, 1, 0, 32'h0);
    issue(17, 0, 1, 3'b100, 32'h100, 32'h0, 1, 32'h0, 1, 0, 32'h0);
    issue(18, 1, 0, 3'b101, 32'h201, 32'h0, 1, 32'h0, 1, 0, 32'h0);
    issue(19, 1, 0, 3'b010, 32'h102, 32'h0, 1, 32'h0, 1, 0, 32'h0);
    issue(20, 1, 0, 3'b110, 32'h200, 32'h0, 1, 32'h0, 1, 0, 32'h0);
    drain();
    check("load_data_held", loadData, 32'h80FF7F01);

    // back-to-back sub-word stores, then loads including a wrapped address
    preload(32'h104, 32'hCAFEF00D);
    issue(21, 0, 1, 3'b001, 32'h106, 32'hFFFF1234, 0, 32'h0, SUB_LAT, SUB_EN, 32'h1234F00D);
    issue(22, 0, 1, 3'b000, 32'h107, 32'h00000055, 0, 32'h0, SUB_LAT, SUB_EN, 32'h5534F00D);
    issue(23, 0, 1, 3'b000, 32'h104, 32'h12345666, 0, 32'h0, SUB_LAT, SUB_EN, 32'h5534F066);
    issue(24, 1, 0, 3'b010, 32'h104, 32'h0, 0, 32'h5534F066, 2, 1, 32'h0);
    issue(25, 0, 1, 3'b001, 32'h104, 32'h0000ABCD, 0, 32'h0, SUB_LAT, SUB_EN, 32'h5534ABCD);
    issue(26, 1, 0, 3'b010, 32'hFFFFF104, 32'h0, 0, 32'h5534ABCD, 2, 1, 32'h0);
    issue(27, 1, 0, 3'b100, 32'hFFFFF107, 32'h0, 0, 32'h00000055, 2, 1, 32'h0);
    drain();

    // reset during the first memory cycle of SH 0xBEEF @0x100
    preload(32'h100, 32'h11223344);
    wr0 = wrCount;
    valid = 1'b1; load = 1'b0; store = 1'b1; mode = 3'b001; addr = 32'h100; sdata = 32'hBEEF;
    check("rst_test_ready", {31'b0, ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    check("rmw_started", {31'b0, rdEn | wrEn}, 32'h1);
    rstN = 1'b0;
    valid = 1'b0;
    #1;
    check("abort_ready", {31'b0, ready}, 32'h1);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_write", wrCount - wr0, 32'h0);
    check("abort_mem_unchanged", mem[8'h40], 32'h11223344);
    check("abort_ready_after", {31'b0, ready}, 32'h1);
    check("abort_load_data_reset", loadData, 32'h0);
    issue(28, 1, 0, 3'b010, 32'h100, 32'h0, 0, 32'h11223344, 2, 1, 32'h0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
